// File: rtl/agu_arb_pkg.sv
// Shared types and constants for the AGU arbiter.
package agu_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRun
  } agu_state_e;

  localparam int unsigned WDOG_LIMIT = 255;

  // Index width that stays legal for a single requester.
  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches upward from last_grant+1 with wrap.
module rr_arbiter
  import agu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [id_width(NUM_REQ)-1:0]    last_grant,
  output logic [NUM_REQ-1:0]              grant,
  output logic [id_width(NUM_REQ)-1:0]    grant_idx
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  logic        found;
  int unsigned cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IdW'(cand);
      end
    end
  end

endmodule

// File: rtl/agu_arbiter.sv
// Shares one address-generation unit between NUM_REQ requesters, round-robin.
// Optional watchdog on a stuck RUN phase: define AGU_ARB_WATCHDOG_EN.
module agu_arbiter
  import agu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned OFF_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_max_reg,
  input  logic [NUM_REQ*3-1:0]            req_vlmul,
  input  logic [NUM_REQ*OFF_WIDTH-1:0]    req_max_off,
  output logic                            agu_en,
  output logic [ADDR_WIDTH-1:0]           agu_addr,
  output logic [ADDR_WIDTH-1:0]           agu_max_reg,
  output logic [2:0]                      agu_vlmul,
  output logic [OFF_WIDTH-1:0]            agu_max_off,
  input  logic                            agu_addr_end,
  output logic [id_width(NUM_REQ)-1:0]    owner_id,
  output logic                            busy,
`ifdef AGU_ARB_WATCHDOG_EN
  output logic                            wdog_err,
`endif
  output logic [NUM_REQ-1:0]              done
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  agu_state_e            state_q, state_d;
  logic [IdW-1:0]        last_grant_q;
  logic [IdW-1:0]        owner_q;
  logic [ADDR_WIDTH-1:0] addr_q, max_reg_q;
  logic [2:0]            vlmul_q;
  logic [OFF_WIDTH-1:0]  max_off_q;

  logic [NUM_REQ-1:0]    grant;
  logic [IdW-1:0]        grant_idx;
  logic                  accept, complete;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

`ifdef AGU_ARB_WATCHDOG_EN
  logic [7:0] wdog_cnt_q;
  logic       wdog_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
    end else if (state_q == StIssue) begin
      wdog_cnt_q <= '0;
    end else if (state_q == StRun) begin
      wdog_cnt_q <= wdog_cnt_q + 8'd1;
    end
  end

  assign wdog_hit = (wdog_cnt_q == 8'(WDOG_LIMIT));
`endif

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
`ifdef AGU_ARB_WATCHDOG_EN
    wdog_err = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        accept = |req_valid;
      end
      StIssue: begin
        if (agu_addr_end) begin
          complete = 1'b1;
          accept   = |req_valid;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (agu_addr_end) begin
          complete = 1'b1;
          accept   = |req_valid;
        end
`ifdef AGU_ARB_WATCHDOG_EN
        else if (wdog_hit) begin
          wdog_err = 1'b1;
          state_d  = StIdle;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
    if (complete) state_d = StIdle;
    if (accept)   state_d = StIssue;
    // Reset wins over everything, including a same-cycle completion.
    if (rst) begin
      state_d  = StIdle;
      accept   = 1'b0;
      complete = 1'b0;
`ifdef AGU_ARB_WATCHDOG_EN
      wdog_err = 1'b0;
`endif
    end
  end

  always_comb begin
    req_ready       = accept ? grant : '0;
    done            = '0;
    done[owner_q]   = complete;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= IdW'(NUM_REQ - 1);
      owner_q      <= '0;
      addr_q       <= '0;
      max_reg_q    <= '0;
      vlmul_q      <= '0;
      max_off_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant_idx;
        owner_q      <= grant_idx;
        addr_q       <= req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        max_reg_q    <= req_max_reg[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        vlmul_q      <= req_vlmul[int'(grant_idx)*3 +: 3];
        max_off_q    <= req_max_off[int'(grant_idx)*OFF_WIDTH +: OFF_WIDTH];
      end
    end
  end

  assign agu_en      = (state_q == StIssue);
  assign busy        = (state_q != StIdle);
  assign owner_id    = owner_q;
  assign agu_addr    = addr_q;
  assign agu_max_reg = max_reg_q;
  assign agu_vlmul   = vlmul_q;
  assign agu_max_off = max_off_q;

endmodule

// File: tb/tb_agu_arbiter.sv
// Directed bench for agu_arbiter; watchdog case built with AGU_ARB_WATCHDOG_EN.
module tb_agu_arbiter;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned OFF_WIDTH  = 8;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_max_reg;
  logic [NUM_REQ*3-1:0]          req_vlmul;
  logic [NUM_REQ*OFF_WIDTH-1:0]  req_max_off;
  logic                          agu_en;
  logic [ADDR_WIDTH-1:0]         agu_addr;
  logic [ADDR_WIDTH-1:0]         agu_max_reg;
  logic [2:0]                    agu_vlmul;
  logic [OFF_WIDTH-1:0]          agu_max_off;
  logic                          agu_addr_end;
  logic [0:0]                    owner_id;
  logic                          busy;
  logic [NUM_REQ-1:0]            done;
`ifdef AGU_ARB_WATCHDOG_EN
  logic                          wdog_err;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  agu_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .OFF_WIDTH  (OFF_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_max_reg  (req_max_reg),
    .req_vlmul    (req_vlmul),
    .req_max_off  (req_max_off),
    .agu_en       (agu_en),
    .agu_addr     (agu_addr),
    .agu_max_reg  (agu_max_reg),
    .agu_vlmul    (agu_vlmul),
    .agu_max_off  (agu_max_off),
    .agu_addr_end (agu_addr_end),
    .owner_id     (owner_id),
    .busy         (busy),
`ifdef AGU_ARB_WATCHDOG_EN
    .wdog_err     (wdog_err),
`endif
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  task automatic reset_dut();
    rst          = 1'b1;
    req_valid    = '0;
    agu_addr_end = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    agu_addr_end = 1'b0;
    // requester 0: addr 8, max_reg 12, vlmul 010, max_off 0x5a
    // requester 1: addr 17, max_reg 20, vlmul 001, max_off 0xc3
    req_addr    = {5'd17, 5'd8};
    req_max_reg = {5'd20, 5'd12};
    req_vlmul   = {3'b001, 3'b010};
    req_max_off = {8'hc3, 8'h5a};

    // Test 1: single request, multi-beat group
    reset_dut();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_agu_en", 32'(agu_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_owner", 32'(owner_id), 32'd0);
    check("rst_addr", 32'(agu_addr), 32'd0);
    req_valid = 2'b01;
    settle();
    check("t1_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    settle();
    check("t1_issue_en", 32'(agu_en), 32'd1);
    check("t1_issue_addr", 32'(agu_addr), 32'd8);
    check("t1_issue_maxreg", 32'(agu_max_reg), 32'd12);
    check("t1_issue_vlmul", 32'(agu_vlmul), 32'b010);
    check("t1_issue_maxoff", 32'(agu_max_off), 32'h5a);
    check("t1_issue_busy", 32'(busy), 32'd1);
    check("t1_issue_ready", 32'(req_ready), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t1_run_en", 32'(agu_en), 32'd0);
      check("t1_run_done", 32'(done), 32'd0);
    end
    tick();
    agu_addr_end = 1'b1;
    settle();
    check("t1_done", 32'(done), 32'b01);
    check("t1_done_busy", 32'(busy), 32'd1);
    tick();
    agu_addr_end = 1'b0;
    settle();
    check("t1_after_busy", 32'(busy), 32'd0);
    check("t1_after_done", 32'(done), 32'd0);
    check("t1_addr_stable", 32'(agu_addr), 32'd8);

    // Test 2: both requesters held valid -> 0,1,0,1 with no bubble
    reset_dut();
    req_valid = 2'b11;
    settle();
    check("t2_ready0", 32'(req_ready), 32'b01);
    for (int k = 0; k < 4; k++) begin
      tick();
      agu_addr_end = 1'b0;
      settle();
      check("t2_issue_en", 32'(agu_en), 32'd1);
      check("t2_owner", 32'(owner_id), 32'(k % 2));
      check("t2_addr", 32'(agu_addr), (k % 2 == 0) ? 32'd8 : 32'd17);
      tick();
      agu_addr_end = 1'b1;
      settle();
      check("t2_done", 32'(done), (k % 2 == 0) ? 32'b01 : 32'b10);
      check("t2_next_ready", 32'(req_ready), (k % 2 == 0) ? 32'b10 : 32'b01);
    end
    tick();
    req_valid    = 2'b00;
    agu_addr_end = 1'b0;
    settle();
    check("t2_drain_en", 32'(agu_en), 32'd1);
    check("t2_drain_owner", 32'(owner_id), 32'd0);
    tick();
    agu_addr_end = 1'b1;
    settle();
    check("t2_drain_done", 32'(done), 32'b01);
    check("t2_drain_ready", 32'(req_ready), 32'd0);
    tick();
    agu_addr_end = 1'b0;
    settle();
    check("t2_idle_busy", 32'(busy), 32'd0);

    // Test 3: single-register groups complete in ISSUE, back to back
    req_vlmul = {3'b000, 3'b000};
    reset_dut();
    req_valid = 2'b11;
    settle();
    check("t3_ready0", 32'(req_ready), 32'b01);
    tick();
    agu_addr_end = 1'b1;
    settle();
    check("t3_issue0_en", 32'(agu_en), 32'd1);
    check("t3_done0", 32'(done), 32'b01);
    check("t3_ready1", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b00;
    settle();
    check("t3_issue1_en", 32'(agu_en), 32'd1);
    check("t3_owner1", 32'(owner_id), 32'd1);
    check("t3_done1", 32'(done), 32'b10);
    tick();
    settle();
    check("t3_idle_end_done", 32'(done), 32'd0);
    check("t3_idle_end_busy", 32'(busy), 32'd0);
    tick();
    agu_addr_end = 1'b0;
    settle();
    check("t3_idle_stays", 32'(busy), 32'd0);

    // Test 4: reset mid-RUN abandons with no done; requester 0 wins next
    req_vlmul = {3'b001, 3'b010};
    reset_dut();
    req_valid = 2'b01;
    settle();
    check("t4_ready0", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    settle();
    check("t4_run_busy", 32'(busy), 32'd1);
    rst          = 1'b1;
    agu_addr_end = 1'b1;
    req_valid    = 2'b11;
    settle();
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst          = 1'b0;
    agu_addr_end = 1'b0;
    settle();
    check("t4_post_busy", 32'(busy), 32'd0);
    check("t4_post_en", 32'(agu_en), 32'd0);
    check("t4_post_addr", 32'(agu_addr), 32'd0);
    check("t4_post_done", 32'(done), 32'd0);
    check("t4_next_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    settle();
    check("t4_next_owner", 32'(owner_id), 32'd0);

`ifdef AGU_ARB_WATCHDOG_EN
    // Test 5: addr_end never arrives -> watchdog after 255 RUN cycles
    reset_dut();
    req_valid = 2'b01;
    settle();
    check("t5_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    tick();
    settle();
    check("t5_run_entry", 32'(wdog_err), 32'd0);
    for (int i = 0; i < 254; i++) tick();
    check("t5_before_err", 32'(wdog_err), 32'd0);
    tick();
    check("t5_err", 32'(wdog_err), 32'd1);
    check("t5_err_done", 32'(done), 32'd0);
    tick();
    check("t5_after_err", 32'(wdog_err), 32'd0);
    check("t5_after_busy", 32'(busy), 32'd0);
    req_valid = 2'b10;
    settle();
    check("t5_reaccept", 32'(req_ready), 32'b10);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
